// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared ISA constants for the MISC-V 16-bit core.
//   - opcode encodings (instruction[2:0])
//   - imm_type_e: immediate format code seen by decode consumers
//   - immediate field widths per format
package misc_v_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_I    = 3'b001;
    localparam logic [2:0] OP_M0   = 3'b010;
    localparam logic [2:0] OP_M1   = 3'b011;
    localparam logic [2:0] OP_Y0   = 3'b100;
    localparam logic [2:0] OP_Y1   = 3'b101;
    localparam logic [2:0] OP_J0   = 3'b110;
    localparam logic [2:0] OP_J1   = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_M    = 3'd2,
        IMM_Y    = 3'd3,
        IMM_J    = 3'd4
    } imm_type_e;

    // Field widths, sign bit included (Y and J include the implicit zero LSB).
    localparam int IMM_I_W = 6;
    localparam int IMM_M_W = 8;
    localparam int IMM_Y_W = 9;
    localparam int IMM_J_W = 11;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational immediate decoder.
// Ports:
//   instruction - input  16 - raw instruction word
//   imm_type    - output  3 - format code (imm_type_e)
//   immediate   - output 16 - sign-extended immediate
// Shared with the disassembler and trace checker, so it holds no state.
module imm_decode
    import misc_v_pkg::*;
(
    input  logic [15:0] instruction,
    output logic [2:0]  imm_type,
    output logic [15:0] immediate
);

    logic [IMM_I_W-1:0] fld_i;
    logic [IMM_M_W-1:0] fld_m;
    logic [IMM_Y_W-1:0] fld_y;
    logic [IMM_J_W-1:0] fld_j;

    // Fields are scattered so that bit 3 is shared across I/M/Y and the
    // sign always comes from as high a bit as the format allows.
    assign fld_i = {instruction[13], instruction[3], instruction[12:9]};
    assign fld_m = {instruction[15], instruction[3], instruction[14:9]};
    assign fld_y = {instruction[15:10], instruction[4:3], 1'b0};
    assign fld_j = {instruction[15:6], 1'b0};

    always_comb begin
        imm_type  = IMM_NONE;
        immediate = 16'h0000;
        unique case (instruction[2:0])
            OP_NONE: begin
                imm_type  = IMM_NONE;
                immediate = 16'h0000;
            end
            OP_I: begin
                imm_type  = IMM_I;
                immediate = {{(16-IMM_I_W){fld_i[IMM_I_W-1]}}, fld_i};
            end
            OP_M0, OP_M1: begin
                imm_type  = IMM_M;
                immediate = {{(16-IMM_M_W){fld_m[IMM_M_W-1]}}, fld_m};
            end
            OP_Y0, OP_Y1: begin
                imm_type  = IMM_Y;
                immediate = {{(16-IMM_Y_W){fld_y[IMM_Y_W-1]}}, fld_y};
            end
            OP_J0, OP_J1: begin
                imm_type  = IMM_J;
                immediate = {{(16-IMM_J_W){fld_j[IMM_J_W-1]}}, fld_j};
            end
            default: begin
                imm_type  = IMM_NONE;
                immediate = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// imm_gen: registered immediate generator for the decode stage.
// Ports:
//   clk         - input   1 - clock, rising edge
//   reset       - input   1 - synchronous, active-high
//   instr_valid - input   1 - instruction meaningful this cycle
//   instruction - input  16 - raw instruction word
//   immediate   - output 16 - registered sign-extended immediate
//   imm_type    - output  3 - registered format code (imm_type_e)
//   imm_valid   - output  1 - registered copy of instr_valid
// One cycle of latency, one instruction per cycle, no stall.
module imm_gen
    import misc_v_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instruction,
    output logic [15:0] immediate,
    output logic [2:0]  imm_type,
    output logic        imm_valid
);

    logic [2:0]  dec_type;
    logic [15:0] dec_imm;

    logic [15:0] immediate_d, immediate_q;
    logic [2:0]  imm_type_d,  imm_type_q;
    logic        imm_valid_d, imm_valid_q;

    imm_decode u_imm_decode (
        .instruction (instruction),
        .imm_type    (dec_type),
        .immediate   (dec_imm)
    );

    // Decode is loaded even when instr_valid is low; consumers qualify
    // with imm_valid, and skipping the enable keeps the register simple.
    always_comb begin
        immediate_d = dec_imm;
        imm_type_d  = dec_type;
        imm_valid_d = instr_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            immediate_q <= 16'h0000;
            imm_type_q  <= IMM_NONE;
            imm_valid_q <= 1'b0;
        end else begin
            immediate_q <= immediate_d;
            imm_type_q  <= imm_type_d;
            imm_valid_q <= imm_valid_d;
        end
    end

    assign immediate = immediate_q;
    assign imm_type  = imm_type_q;
    assign imm_valid = imm_valid_q;

endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: self-checking bench for imm_gen. Directed cases plus a
// randomized stream compared against an arithmetic reference model.
module tb_imm_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic [2:0]  imm_type;
    logic        imm_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .immediate   (immediate),
        .imm_type    (imm_type),
        .imm_valid   (imm_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: immediate value as a weighted sum of instruction bits,
    // sign bit carrying negative weight.
    function automatic int ref_imm(input logic [15:0] x);
        int b3  = int'(x[3]);
        int b4  = int'(x[4]);
        int b13 = int'(x[13]);
        int b15 = int'(x[15]);
        case (x[2:0])
            3'd1:       return int'(x[12:9]) + 16*b3 - 32*b13;
            3'd2, 3'd3: return int'(x[14:9]) + 64*b3 - 128*b15;
            3'd4, 3'd5: return 2*b3 + 4*b4 + 8*int'(x[14:10]) - 256*b15;
            3'd6, 3'd7: return 2*int'(x[14:6]) - 1024*b15;
            default:    return 0;
        endcase
    endfunction

    function automatic int ref_type(input logic [15:0] x);
        case (x[2:0])
            3'd0:       return 0;
            3'd1:       return 1;
            3'd2, 3'd3: return 2;
            3'd4, 3'd5: return 3;
            default:    return 4;
        endcase
    endfunction

    // Apply one cycle of inputs, then check outputs #1 after the edge.
    task automatic step(input string tag, input logic rst, input logic vld, input logic [15:0] ins);
        int v;
        reset       = rst;
        instr_valid = vld;
        instruction = ins;
        @(posedge clk);
        #1;
        if (rst) begin
            chk({tag, ".imm"},   32'(immediate), 32'h0);
            chk({tag, ".type"},  32'(imm_type),  32'h0);
            chk({tag, ".valid"}, 32'(imm_valid), 32'h0);
        end else begin
            v = ref_imm(ins);
            chk({tag, ".imm"},   32'(immediate), 32'(v[15:0]));
            chk({tag, ".type"},  32'(imm_type),  32'(ref_type(ins)));
            chk({tag, ".valid"}, 32'(imm_valid), 32'(vld));
        end
    endtask

    task automatic exp_imm(input string tag, input logic [15:0] ins, input logic [15:0] e);
        step(tag, 1'b0, 1'b1, ins);
        chk({tag, ".lit"}, 32'(immediate), 32'(e));
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b1; instruction = 16'hFFFF;
        @(negedge clk);
        step("rst0", 1'b1, 1'b1, 16'hFFFF);
        step("rst1", 1'b1, 1'b1, 16'hFFFF);
        step("rel",  1'b0, 1'b1, 16'hFFFF);
        chk("rel.lit", 32'(immediate), 32'hFFFE);
        chk("rel.j",   32'(imm_type),  32'd4);

        exp_imm("i_one", 16'b0000001000000001, 16'h0001);
        exp_imm("i_min", 16'b0010000000000001, 16'hFFE0);
        exp_imm("i_b3",  16'b0000000000001001, 16'h0010);
        exp_imm("m0_1",  16'b0000001000000010, 16'h0001);
        exp_imm("m1_1",  16'b0000001000000011, 16'h0001);
        exp_imm("m0_mn", 16'b1000000000000010, 16'hFF80);
        exp_imm("m1_mn", 16'b1000000000000011, 16'hFF80);
        exp_imm("y0_2",  16'b0000000000001100, 16'h0002);
        exp_imm("y1_2",  16'b0000000000001101, 16'h0002);
        exp_imm("y0_mn", 16'b1000000000000100, 16'hFF00);
        exp_imm("y1_mn", 16'b1000000000000101, 16'hFF00);
        exp_imm("j0_2",  16'b0000000001000110, 16'h0002);
        exp_imm("j1_2",  16'b0000000001000111, 16'h0002);
        exp_imm("j0_mn", 16'b1000000000000110, 16'hFC00);
        exp_imm("j1_mn", 16'b1000000000000111, 16'hFC00);
        exp_imm("j_max", 16'b0111111111000110, 16'h03FE);
        exp_imm("i_max", 16'b1101111000001001, 16'h001F);
        exp_imm("none",  16'hFFF8, 16'h0000);

        // Back-to-back stream with one bubble in the middle.
        step("bb_i", 1'b0, 1'b1, 16'b0010000000000001);
        step("bb_m", 1'b0, 1'b1, 16'b1000000000000010);
        step("bb_y", 1'b0, 1'b0, 16'b1000000000000100);
        step("bb_j", 1'b0, 1'b1, 16'b0111111111000110);
        step("bb_n", 1'b0, 1'b1, 16'hFFF8);

        // Mid-stream reset discards the in-flight result.
        step("mrst", 1'b1, 1'b1, 16'h7FC6);
        step("post", 1'b0, 1'b1, 16'h1234);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] r;
            r = 16'($urandom);
            step("rnd", ($urandom_range(0, 31) == 0), 1'($urandom), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
